// File: rtl/vga_timing_gen_p.sv
// vga_timing_gen_p: parametrised VGA timing generator with fetch-timed coordinates and delay-aligned syncs/display enable
module vga_timing_gen_p #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int PIPE_DLY   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_pix_en,
  output logic                        o_draw_active,
  output logic [$clog2(H_ACTIVE)-1:0] o_active_x,
  output logic [$clog2(V_ACTIVE)-1:0] o_active_y,
  output logic                        o_line_start,
  output logic                        o_frame_start,
  output logic                        o_disp_active,
  output logic                        o_h_sync,
  output logic                        o_v_sync
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int AXW = $clog2(H_ACTIVE);
  localparam int AYW = $clog2(V_ACTIVE);
  localparam logic HP = H_SYNC_POL != 0;
  localparam logic VP = V_SYNC_POL != 0;
  localparam logic [2:0] IDLE = {1'b0, !HP, !VP};
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic da, hs, vs, x_wrap;
  logic [2:0] dl [PIPE_DLY+1];
  always_comb begin
    x_wrap = x == XW'(H_TOTAL - 1);
    da = x < XW'(H_ACTIVE) && y < YW'(V_ACTIVE);
    hs = x >= XW'(H_ACTIVE + H_FRONT) && x < XW'(H_ACTIVE + H_FRONT + H_SYNC);
    vs = y >= YW'(V_ACTIVE + V_FRONT) && y < YW'(V_ACTIVE + V_FRONT + V_SYNC);
  end
  // dl[0] is the fetch-timed triple; dl[PIPE_DLY] drives the pins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      o_active_x <= '0;
      o_active_y <= '0;
      o_line_start <= 1'b0;
      o_frame_start <= 1'b0;
      for (int i = 0; i <= PIPE_DLY; i++) dl[i] <= IDLE;
    end else if (i_pix_en) begin
      x <= x_wrap ? '0 : x + 1'b1;
      if (x_wrap) y <= (y == YW'(V_TOTAL - 1)) ? '0 : y + 1'b1;
      o_active_x <= da ? x[AXW-1:0] : '0;
      o_active_y <= da ? y[AYW-1:0] : '0;
      o_line_start <= x == '0;
      o_frame_start <= x == '0 && y == '0;
      dl[0] <= {da, hs ~^ HP, vs ~^ VP};
      for (int i = 1; i <= PIPE_DLY; i++) dl[i] <= dl[i-1];
    end
  end
  assign o_draw_active = dl[0][2];
  assign {o_disp_active, o_h_sync, o_v_sync} = dl[PIPE_DLY];
endmodule

// File: tb/tb_vga_timing_gen_p.sv
// tb_vga_timing_gen_p: randomized checks of three timing generator configurations against an arithmetic model
module tb_vga_timing_gen_p;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic rst_a, en_a, rst_b, en_b, rst_c, en_c;
  logic a_draw, a_ls, a_fs, a_disp, a_hs, a_vs;
  logic [1:0] a_x, a_y;
  logic b_draw, b_ls, b_fs, b_disp, b_hs, b_vs;
  logic [1:0] b_x, b_y;
  logic c_draw, c_ls, c_fs, c_disp, c_hs, c_vs;
  logic [9:0] c_x;
  logic [8:0] c_y;
  vga_timing_gen_p #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .H_SYNC_POL(1), .V_SYNC_POL(0), .PIPE_DLY(3)) u_a (
    .clk(clk), .rst_n(rst_a), .i_pix_en(en_a), .o_draw_active(a_draw), .o_active_x(a_x),
    .o_active_y(a_y), .o_line_start(a_ls), .o_frame_start(a_fs), .o_disp_active(a_disp),
    .o_h_sync(a_hs), .o_v_sync(a_vs));
  vga_timing_gen_p #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .H_SYNC_POL(0), .V_SYNC_POL(0), .PIPE_DLY(0)) u_b (
    .clk(clk), .rst_n(rst_b), .i_pix_en(en_b), .o_draw_active(b_draw), .o_active_x(b_x),
    .o_active_y(b_y), .o_line_start(b_ls), .o_frame_start(b_fs), .o_disp_active(b_disp),
    .o_h_sync(b_hs), .o_v_sync(b_vs));
  vga_timing_gen_p u_c (
    .clk(clk), .rst_n(rst_c), .i_pix_en(en_c), .o_draw_active(c_draw), .o_active_x(c_x),
    .o_active_y(c_y), .o_line_start(c_ls), .o_frame_start(c_fs), .o_disp_active(c_disp),
    .o_h_sync(c_hs), .o_v_sync(c_vs));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // k = enabled edges since reset; fetch outputs show position k-1, pins show k-1-d
  function automatic logic [63:0] model(input int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, d, input longint k);
    int ht, vt, x, y, ax, ay;
    longint p;
    logic draw, ls, fs, dd, hh, vv;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    draw = 0; ls = 0; fs = 0; ax = 0; ay = 0; dd = 0;
    hh = (hp == 0); vv = (vp == 0);
    if (k > 0) begin
      p = k - 1;
      x = int'(p % ht);
      y = int'((p / ht) % vt);
      draw = x < ha && y < va;
      ax = draw ? x : 0;
      ay = draw ? y : 0;
      ls = x == 0;
      fs = x == 0 && y == 0;
    end
    if (k > d) begin
      p = k - 1 - d;
      x = int'(p % ht);
      y = int'((p / ht) % vt);
      dd = x < ha && y < va;
      hh = (x >= ha + hf && x < ha + hf + hs) ? (hp != 0) : (hp == 0);
      vv = (y >= va + vf && y < va + vf + vs) ? (vp != 0) : (vp == 0);
    end
    return {26'b0, draw, ls, fs, dd, hh, vv, 16'(ax), 16'(ay)};
  endfunction
  longint ka = 0, kb = 0, kc = 0;
  int last_fs = -1, last_ls = -1;
  initial begin
    rst_a = 0; rst_b = 0; rst_c = 0;
    en_a = 1; en_b = 1; en_c = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      ka = !rst_a ? 0 : en_a ? ka + 1 : ka;
      kb = !rst_b ? 0 : en_b ? kb + 1 : kb;
      kc = !rst_c ? 0 : en_c ? kc + 1 : kc;
      check("A", {26'b0, a_draw, a_ls, a_fs, a_disp, a_hs, a_vs, 16'(a_x), 16'(a_y)},
            model(4, 1, 2, 1, 3, 1, 1, 1, 1, 0, 3, ka));
      check("B", {26'b0, b_draw, b_ls, b_fs, b_disp, b_hs, b_vs, 16'(b_x), 16'(b_y)},
            model(4, 1, 2, 1, 3, 1, 1, 1, 0, 0, 0, kb));
      check("C", {26'b0, c_draw, c_ls, c_fs, c_disp, c_hs, c_vs, 16'(c_x), 16'(c_y)},
            model(640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, kc));
      if (!rst_b) last_fs = -1;
      else if (b_fs) begin
        if (last_fs >= 0) check("B_frame_period", 64'(cyc - last_fs), 64'd48);
        last_fs = cyc;
      end
      if (c_ls) begin
        if (last_ls >= 0) check("C_line_period", 64'(cyc - last_ls), 64'd800);
        last_ls = cyc;
      end
      rst_a = cyc >= 3 && ($urandom_range(0, 299) != 0);
      en_a = 1'($urandom_range(0, 1));
      rst_b = cyc >= 3 && kb != 107;
      en_b = 1'b1;
      rst_c = cyc >= 3;
      en_c = 1'b1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen_p.md
Name: vga_timing_gen_p

Overview:
Parametrised successor to the fixed-mode VGA timing generator. All horizontal and vertical timings are parameters, with per-axis sync polarity and a pixel-clock enable. A configurable delay line aligns sync and display-enable with a downstream pixel pipeline. The block sits between the cell-grid renderer, which consumes the fetch-timed coordinates, and the VGA pins, which receive the delayed syncs and display enable.

Parameters:
H_ACTIVE, 640, visible pixels per line (>=2)
H_FRONT, 16, horizontal front porch in pixels (>=1)
H_SYNC, 96, horizontal sync width in pixels (>=1)
H_BACK, 48, horizontal back porch in pixels (>=1)
V_ACTIVE, 480, visible lines per frame (>=2)
V_FRONT, 10, vertical front porch in lines (>=1)
V_SYNC, 2, vertical sync width in lines (>=1)
V_BACK, 33, vertical back porch in lines (>=1)
H_SYNC_POL, 0, asserted level of o_h_sync (0 = active-low)
V_SYNC_POL, 0, asserted level of o_v_sync
PIPE_DLY, 2, extra pixel ticks applied to o_h_sync/o_v_sync/o_disp_active (0..7)

Ports:
clk  in  1  system clock; one clock, all logic on posedge
rst_n  in  1  synchronous, active-low reset
i_pix_en  in  1  pixel tick; position advances only on cycles with i_pix_en=1
o_draw_active  out  1  fetch-timed: current position is inside the active area
o_active_x  out  $clog2(H_ACTIVE)  fetch-timed column; 0 when o_draw_active=0
o_active_y  out  $clog2(V_ACTIVE)  fetch-timed row; 0 when o_draw_active=0
o_line_start  out  1  fetch-timed: position x==0, any line
o_frame_start  out  1  fetch-timed: position x==0 and y==0
o_disp_active  out  1  o_draw_active delayed by PIPE_DLY ticks
o_h_sync  out  1  horizontal sync, delayed by PIPE_DLY ticks, polarity per H_SYNC_POL
o_v_sync  out  1  vertical sync, delayed by PIPE_DLY ticks, polarity per V_SYNC_POL

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined likewise.
- Internal counters: x has width $clog2(H_TOTAL) and y has width $clog2(V_TOTAL). Both are 0 during reset.
- On a clock edge with i_pix_en=1:
  - x increments, wrapping H_TOTAL-1 -> 0.
  - y increments only when x wraps, wrapping V_TOTAL-1 -> 0.
- On a clock edge with i_pix_en=0, all state holds, including the outputs and the delay line.
- All outputs are registered. On each enabled edge, the fetch-timed outputs load the decode of the pre-increment position (x,y).
  - Equivalently: after the n-th enabled edge following reset release (n counted from 0), the fetch-timed outputs show position n.
  - Latency from counter to output is one enabled tick.
- Decode rules:
  - draw_active = (x<H_ACTIVE)&&(y<V_ACTIVE).
  - Horizontal sync is asserted for x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
  - Vertical sync is asserted for y in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], over whole lines including blanked pixels.
- Output sync level: if asserted then xx_SYNC_POL, else !xx_SYNC_POL.
- Delay line:
  - PIPE_DLY stages carry {draw_active, hsync, vsync} and shift only on enabled edges.
  - o_disp_active, o_h_sync and o_v_sync therefore show position n-PIPE_DLY.
  - With PIPE_DLY=0 they are coincident with o_draw_active.
- Reset values, held while rst_n=0 regardless of i_pix_en:
  - o_draw_active=0, o_active_x=0, o_active_y=0, o_line_start=0, o_frame_start=0, o_disp_active=0.
  - o_h_sync=!H_SYNC_POL, o_v_sync=!V_SYNC_POL.
  - Every delay-line stage is held at the inactive triple.
- Reset asserted mid-frame: on the next edge, the counters, outputs and delay line all return to their reset values.
- After reset release: the first enabled edge presents position (0,0), so o_frame_start=1 and o_line_start=1. The delayed outputs stay inactive for the first PIPE_DLY enabled edges.
- Simultaneous frame wrap (x=H_TOTAL-1, y=V_TOTAL-1) on an enabled edge: the next position is (0,0) and o_frame_start=1 on the following enabled edge.
- o_active_x/o_active_y never exceed H_ACTIVE-1 and V_ACTIVE-1.

Test Plan:
1. Small mode, PIPE_DLY=0, i_pix_en=1 constantly. Mode: H_ACTIVE=4, H_FRONT=1, H_SYNC=2, H_BACK=1 (H_TOTAL=8); V_ACTIVE=3, V_FRONT=1, V_SYNC=1, V_BACK=1 (V_TOTAL=6).
   -> o_active_x sequence 0,1,2,3 with draw=1, then 4 cycles draw=0 and x=0.
   -> o_h_sync=0 at positions x=5,6 only.
   -> o_v_sync=0 for all 8 pixels of y=4.
   -> o_frame_start=1 every 48 cycles.
2. Same mode with PIPE_DLY=3.
   -> o_disp_active/o_h_sync/o_v_sync equal the PIPE_DLY=0 waveform shifted by exactly 3 cycles.
   -> First 3 cycles after reset: o_disp_active=0, syncs=1.
3. i_pix_en toggled 1,0,1,0.
   -> All outputs hold on disabled cycles.
   -> Pixel sequence identical to scenario 1 at half rate; frame period 96 clocks.
4. H_SYNC_POL=1, V_SYNC_POL=0.
   -> o_h_sync=0 in reset, high only at x=5,6.
   -> o_v_sync low only at y=4.
5. rst_n dropped at position (2,1) for 1 cycle, with i_pix_en=1 asserted during reset.
   -> Outputs forced to reset values.
   -> First edge after release shows (0,0) with o_frame_start=1; delay line flushed to inactive.
6. Default 640x480 parameters, i_pix_en=1, run 2 frames.
   -> Frame period 420000 cycles.
   -> o_line_start period 800 cycles.
   -> o_draw_active high for 307200 cycles per frame.
